// File: rtl/fma_dot_sequencer.sv
// ---------------------------------------------------------------------------
// fma_dot_sequencer
//
// Drives one FMA lane through a dot product  res = bias + sum(a[i]*b[i])
// over N consecutive {a,b} operand words in a packed operand memory.
// One command is processed at a time.
//
// Compile-time option:
//   FMA_SEQ_STRIDE_EN  - when defined, adds cmd_stride_in and the read address
//                        steps by the latched stride. Otherwise the stride is 1.
//
// Ports:
//   clk_in, rst_in                  clock, asynchronous active-high reset
//   cmd_valid_in / cmd_ready_out    command handshake (ready only in IDLE)
//   cmd_addr_in, cmd_len_in,        base address, element count N, bias
//   cmd_bias_in, [cmd_stride_in]    (stride only with FMA_SEQ_STRIDE_EN)
//   rd_en_out, rd_addr_out          operand memory read request
//   rd_data_in                      {a,b}, returned one cycle after rd_en_out
//   fma_abc_out, fma_valid_out,     operands and strobes to the FMA
//   fma_c_valid_out
//   fma_out_in, fma_valid_in        FMA result stream
//   res_valid_out / res_ready_in    result handshake, res_data_out payload
//   busy_out                        high whenever not IDLE
// ---------------------------------------------------------------------------
module fma_dot_sequencer #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 cmd_valid_in,
    output logic                 cmd_ready_out,
    input  logic [ADDR_W-1:0]    cmd_addr_in,
    input  logic [LEN_W-1:0]     cmd_len_in,
    input  logic [WIDTH-1:0]     cmd_bias_in,
`ifdef FMA_SEQ_STRIDE_EN
    input  logic [ADDR_W-1:0]    cmd_stride_in,
`endif
    output logic                 rd_en_out,
    output logic [ADDR_W-1:0]    rd_addr_out,
    input  logic [2*WIDTH-1:0]   rd_data_in,
    output logic [3*WIDTH-1:0]   fma_abc_out,
    output logic                 fma_valid_out,
    output logic                 fma_c_valid_out,
    input  logic [WIDTH-1:0]     fma_out_in,
    input  logic                 fma_valid_in,
    output logic                 res_valid_out,
    input  logic                 res_ready_in,
    output logic [WIDTH-1:0]     res_data_out,
    output logic                 busy_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [ADDR_W-1:0]  addr_p0;      // address issued this cycle
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   issue_cnt;    // reads issued so far
    logic [LEN_W-1:0]   done_cnt;     // FMA results seen so far
    logic [WIDTH-1:0]   bias_reg;
    logic [WIDTH-1:0]   res_reg;
    logic [ADDR_W-1:0]  stride_cur;
    logic               vld_p1;       // read data present on rd_data_in
    logic               first_p1;     // ... and it is element 0

    logic               cmd_fire;
    logic               issue_last;
    logic               drain_hit;
    logic               fetching;

`ifdef FMA_SEQ_STRIDE_EN
    logic [ADDR_W-1:0]  stride_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stride_reg <= '0;
        end else if (cmd_fire) begin
            stride_reg <= cmd_stride_in;
        end
    end

    assign stride_cur = stride_reg;
`else
    assign stride_cur = ADDR_W'(1);
`endif

    assign cmd_fire   = cmd_valid_in && (state == S_IDLE);
    assign fetching   = (state == S_FETCH);
    assign issue_last = (issue_cnt == len_reg - 1'b1);
    // The Nth FMA result can only arrive after the last issue, i.e. in DRAIN.
    assign drain_hit  = fma_valid_in && (state == S_DRAIN)
                        && (done_cnt == len_reg - 1'b1);

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_ready_out = 1'b0;
        rd_en_out     = 1'b0;
        res_valid_out = 1'b0;
        busy_out      = 1'b1;
        case (state)
            S_IDLE: begin
                cmd_ready_out = 1'b1;
                busy_out      = 1'b0;
                if (cmd_valid_in) begin
                    state_nxt = (cmd_len_in == '0) ? S_RESULT : S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en_out = 1'b1;
                if (issue_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_hit) begin
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                res_valid_out = 1'b1;
                if (res_ready_in) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- stage p0: command latch and read issue ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_p0   <= '0;
            len_reg   <= '0;
            bias_reg  <= '0;
            issue_cnt <= '0;
        end else if (cmd_fire) begin
            addr_p0   <= cmd_addr_in;
            len_reg   <= cmd_len_in;
            bias_reg  <= cmd_bias_in;
            issue_cnt <= '0;
        end else if (fetching) begin
            // Wraps modulo 2^ADDR_W by construction.
            addr_p0   <= addr_p0 + stride_cur;
            issue_cnt <= issue_cnt + 1'b1;
        end
    end

    assign rd_addr_out = addr_p0;

    // ---------------- stage p1: read data returns, feed FMA ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
        end else begin
            vld_p1   <= fetching;
            first_p1 <= fetching && (issue_cnt == '0);
        end
    end

    assign fma_valid_out   = vld_p1;
    assign fma_c_valid_out = vld_p1 && first_p1;
    // Operands are gated so the bus idles at zero between commands.
    assign fma_abc_out     = vld_p1 ? {rd_data_in, bias_reg} : '0;

    // ---------------- stage p2: FMA results, capture final sum ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            done_cnt <= '0;
            res_reg  <= '0;
        end else if (cmd_fire) begin
            done_cnt <= '0;
            if (cmd_len_in == '0) begin
                res_reg <= cmd_bias_in;
            end
        end else if (fma_valid_in && (fetching || state == S_DRAIN)) begin
            done_cnt <= done_cnt + 1'b1;
            if (drain_hit) begin
                res_reg <= fma_out_in;
            end
        end
    end

    assign res_data_out = res_reg;

endmodule
